// File: rtl/slot_pkg.sv
// Shared types and constants for the three-reel slot controller.
package slot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPIN,
    STOP1,
    STOP2,
    EVAL
  } state_t;

  localparam logic [1:0] WIN_NONE   = 2'd0;
  localparam logic [1:0] WIN_PAIR   = 2'd1;
  localparam logic [1:0] WIN_TRIPLE = 2'd2;

  localparam int unsigned REEL0_STEP = 1;
  localparam int unsigned REEL1_STEP = 3;
  localparam int unsigned REEL2_STEP = 5;

  // Advance a reel index by step modulo num_sym; cur is always < num_sym.
  function automatic int unsigned reel_next(input int unsigned cur, input int unsigned step,
                                            input int unsigned num_sym);
    int unsigned s;
    int unsigned t;
    s = step % num_sym;
    t = cur + s;
    if (t >= num_sym) t = t - num_sym;
    return t;
  endfunction

endpackage

// File: rtl/slot_tick_detect.sv
// Rising-edge detector turning the slow sclk square wave into one-cycle game ticks.
// Build option SLOT_REEL_SYNC_EN adds a 2-flop synchronizer in front (tick latency 3 cycles
// instead of 1).
module slot_tick_detect (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  output logic tick
);

  logic sclk_in;
  logic sclk_r;
  logic sclk_prev;

`ifdef SLOT_REEL_SYNC_EN
  logic sync1;
  logic sync2;

  // Two-stage synchronizer for an sclk that is asynchronous to clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= sclk;
      sync2 <= sync1;
    end
  end

  assign sclk_in = sync2;
`else
  assign sclk_in = sclk;
`endif

  // Registered sample plus one cycle of history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_r    <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      sclk_r    <= sclk_in;
      sclk_prev <= sclk_r;
    end
  end

  assign tick = sclk_r & ~sclk_prev;

endmodule

// File: rtl/slot_reel_ctrl.sv
// Three-reel slot game sequencer: spins reels, stops one per sclk tick, scores the result and
// keeps a saturating credit balance. Build option SLOT_REEL_SYNC_EN selects a synchronized sclk.
module slot_reel_ctrl
  import slot_pkg::*;
#(
  parameter int unsigned NUM_SYM    = 8,
  parameter int unsigned SYM_W      = 4,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned PAIR_PAY   = 2,
  parameter int unsigned TRIPLE_PAY = 10,
  parameter int unsigned SPIN_TICKS = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                coin,
  input  logic                start,
  output logic [SYM_W-1:0]    reel0,
  output logic [SYM_W-1:0]    reel1,
  output logic [SYM_W-1:0]    reel2,
  output logic                busy,
  output logic                done,
  output logic [1:0]          win,
  output logic [CREDIT_W-1:0] credits
);

  localparam int unsigned CNT_W = $clog2(SPIN_TICKS + 1);
  // Headroom so credit + coin + payout never wraps before saturation.
  localparam int unsigned SUM_W = CREDIT_W + 8;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SYM_W-1:0]    reel0_q, reel1_q, reel2_q;
  logic [SYM_W-1:0]    reel0_d, reel1_d, reel2_d;
  logic [1:0]          win_q, win_d;
  logic                done_q, done_d;
  logic [CREDIT_W-1:0] credits_q, credits_d;

  logic             tick;
  logic             adv0, adv1, adv2;
  logic             debit;
  logic [SUM_W-1:0] pay;
  logic [SUM_W-1:0] sum;
  logic [1:0]       win_eval;

  slot_tick_detect u_tick (
    .clk   (clk),
    .reset (reset),
    .sclk  (sclk),
    .tick  (tick)
  );

  // Score the frozen reels; two equal pairs imply a triple, so any single match is a pair.
  always_comb begin
    win_eval = WIN_NONE;
    if (reel0_q == reel1_q && reel1_q == reel2_q) begin
      win_eval = WIN_TRIPLE;
    end else if (reel0_q == reel1_q || reel1_q == reel2_q || reel0_q == reel2_q) begin
      win_eval = WIN_PAIR;
    end
  end

  // Game FSM: next state, which reels move this cycle, debit and payout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    done_d  = 1'b0;
    debit   = 1'b0;
    pay     = '0;
    adv0    = 1'b0;
    adv1    = 1'b0;
    adv2    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && credits_q != '0) begin
          debit   = 1'b1;
          win_d   = WIN_NONE;
          cnt_d   = '0;
          state_d = SPIN;
        end
      end
      SPIN: begin
        adv0 = 1'b1;
        adv1 = 1'b1;
        adv2 = 1'b1;
        if (tick) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (32'(cnt_q) + 32'd1 >= SPIN_TICKS) begin
            adv0    = 1'b0;
            state_d = STOP1;
          end
        end
      end
      STOP1: begin
        adv1 = 1'b1;
        adv2 = 1'b1;
        if (tick) begin
          adv1    = 1'b0;
          state_d = STOP2;
        end
      end
      STOP2: begin
        adv2 = 1'b1;
        if (tick) begin
          adv2    = 1'b0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        win_d  = win_eval;
        done_d = 1'b1;
        if (win_eval == WIN_TRIPLE) pay = SUM_W'(TRIPLE_PAY);
        else if (win_eval == WIN_PAIR) pay = SUM_W'(PAIR_PAY);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Reel stepping; a reel holds the value shown on the tick that freezes it.
  always_comb begin
    reel0_d = adv0 ? SYM_W'(reel_next(32'(reel0_q), REEL0_STEP, NUM_SYM)) : reel0_q;
    reel1_d = adv1 ? SYM_W'(reel_next(32'(reel1_q), REEL1_STEP, NUM_SYM)) : reel1_q;
    reel2_d = adv2 ? SYM_W'(reel_next(32'(reel2_q), REEL2_STEP, NUM_SYM)) : reel2_q;
  end

  // Credits: net of coin, debit and payout, then saturate; debit never underflows (credits > 0).
  always_comb begin
    sum = SUM_W'(credits_q) + SUM_W'(coin) + pay - SUM_W'(debit);
    if (sum > SUM_W'({CREDIT_W{1'b1}})) credits_d = {CREDIT_W{1'b1}};
    else credits_d = sum[CREDIT_W-1:0];
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      reel0_q   <= '0;
      reel1_q   <= '0;
      reel2_q   <= '0;
      win_q     <= WIN_NONE;
      done_q    <= 1'b0;
      credits_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      reel0_q   <= reel0_d;
      reel1_q   <= reel1_d;
      reel2_q   <= reel2_d;
      win_q     <= win_d;
      done_q    <= done_d;
      credits_q <= credits_d;
    end
  end

  assign reel0   = reel0_q;
  assign reel1   = reel1_q;
  assign reel2   = reel2_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign win     = win_q;
  assign credits = credits_q;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed bench for slot_reel_ctrl: table of spins with hand-computed reel/score/credit
// results, plus sequences for idle ticks, coin saturation and reset mid-spin.
module tb_slot_reel_ctrl;

`ifdef SLOT_REEL_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic       clk;
  logic       reset;
  logic       sclk;
  logic       coin;
  logic       start;
  logic [3:0] reel0, reel1, reel2;
  logic       busy;
  logic       done;
  logic [1:0] win;
  logic [7:0] credits;

  int n_checks = 0;
  int n_pass   = 0;

  slot_reel_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .sclk    (sclk),
    .coin    (coin),
    .start   (start),
    .reel0   (reel0),
    .reel1   (reel1),
    .reel2   (reel2),
    .busy    (busy),
    .done    (done),
    .win     (win),
    .credits (credits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int pre_coin;  // coin cycles before start
    int cws;       // coin high in the start cycle
    int g0, g1, g2;
    int r0, r1, r2;
    int win;
    int cpre, cstart, cfin;
  } vec_t;

  vec_t tbl [4];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, exp);
  endtask

  // Tick the FSM so the current state lasts exactly g+2 cycles, independent of tick latency.
  task automatic stage(input int g);
    repeat (g - LAT + 1) @(posedge clk);
    #1 sclk = 1'b1;
    repeat (LAT + 1) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  task automatic toggle_sclk(input int n);
    for (int k = 0; k < n; k++) begin
      sclk = 1'b1;
      repeat (4) @(posedge clk);
      #1 sclk = 1'b0;
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    // Reels after n advances from (a,b,c): (a+n0, b+3*n1, c+5*n2) mod 8,
    // with n0=g0+1, n1=g0+g1+3, n2=g0+g1+g2+5.
    tbl[0] = '{pre_coin: 3,   cws: 0, g0: 3, g1: 6, g2: 6, r0: 4, r1: 4, r2: 4, win: 2,
               cpre: 3,   cstart: 2,   cfin: 12};
    tbl[1] = '{pre_coin: 0,   cws: 0, g0: 9, g1: 9, g2: 9, r0: 6, r1: 3, r2: 4, win: 0,
               cpre: 12,  cstart: 11,  cfin: 11};
    tbl[2] = '{pre_coin: 0,   cws: 0, g0: 9, g1: 9, g2: 5, r0: 0, r1: 2, r2: 0, win: 1,
               cpre: 11,  cstart: 10,  cfin: 12};
    tbl[3] = '{pre_coin: 242, cws: 1, g0: 9, g1: 4, g2: 8, r0: 2, r1: 2, r2: 2, win: 2,
               cpre: 254, cstart: 254, cfin: 255};

    reset = 1'b1;
    sclk  = 1'b0;
    coin  = 1'b0;
    start = 1'b0;
    #2;
    check("rst reel0", int'(reel0), 0);
    check("rst reel1", int'(reel1), 0);
    check("rst reel2", int'(reel2), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    check("rst win", int'(win), 0);
    check("rst credits", int'(credits), 0);
    #10 reset = 1'b0;
    @(posedge clk);
    #1;

    // Start with no credits is ignored.
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    check("nocredit busy", int'(busy), 0);
    check("nocredit credits", int'(credits), 0);

    for (int i = 0; i < 4; i++) begin
      if (tbl[i].pre_coin > 0) begin
        coin = 1'b1;
        repeat (tbl[i].pre_coin) @(posedge clk);
        #1 coin = 1'b0;
      end
      check($sformatf("spin%0d pre credits", i), int'(credits), tbl[i].cpre);
      start = 1'b1;
      coin  = tbl[i].cws[0];
      @(posedge clk);
      #1 start = 1'b0;
      coin = 1'b0;
      check($sformatf("spin%0d start busy", i), int'(busy), 1);
      check($sformatf("spin%0d start credits", i), int'(credits), tbl[i].cstart);
      check($sformatf("spin%0d start win", i), int'(win), 0);
      stage(tbl[i].g0);
      check($sformatf("spin%0d stop0 reel0", i), int'(reel0), tbl[i].r0);
      stage(tbl[i].g1);
      check($sformatf("spin%0d stop1 reel0", i), int'(reel0), tbl[i].r0);
      check($sformatf("spin%0d stop1 reel1", i), int'(reel1), tbl[i].r1);
      stage(tbl[i].g2);
      check($sformatf("spin%0d stop2 reel2", i), int'(reel2), tbl[i].r2);
      check($sformatf("spin%0d eval busy", i), int'(busy), 1);
      check($sformatf("spin%0d eval done", i), int'(done), 0);
      @(posedge clk);
      #1;
      check($sformatf("spin%0d done", i), int'(done), 1);
      check($sformatf("spin%0d end busy", i), int'(busy), 0);
      check($sformatf("spin%0d win", i), int'(win), tbl[i].win);
      check($sformatf("spin%0d credits", i), int'(credits), tbl[i].cfin);
      check($sformatf("spin%0d reel0", i), int'(reel0), tbl[i].r0);
      check($sformatf("spin%0d reel1", i), int'(reel1), tbl[i].r1);
      check($sformatf("spin%0d reel2", i), int'(reel2), tbl[i].r2);
      @(posedge clk);
      #1;
      check($sformatf("spin%0d done pulse", i), int'(done), 0);
      check($sformatf("spin%0d win held", i), int'(win), tbl[i].win);
    end

    // Ticks while idle change nothing.
    toggle_sclk(3);
    check("idle tick busy", int'(busy), 0);
    check("idle tick credits", int'(credits), 255);
    check("idle tick reel0", int'(reel0), 2);
    check("idle tick reel2", int'(reel2), 2);
    check("idle tick win", int'(win), 2);

    // Coin at full balance stays saturated.
    coin = 1'b1;
    repeat (5) @(posedge clk);
    #1 coin = 1'b0;
    check("coin sat credits", int'(credits), 255);

    // Reset during STOP1 clears everything immediately; the debited credit is lost.
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("rstspin start credits", int'(credits), 254);
    stage(3);
    check("rstspin stop1 busy", int'(busy), 1);
    check("rstspin stop1 reel0", int'(reel0), 6);
    #2 reset = 1'b1;
    #1;
    check("midrst reel0", int'(reel0), 0);
    check("midrst reel1", int'(reel1), 0);
    check("midrst reel2", int'(reel2), 0);
    check("midrst busy", int'(busy), 0);
    check("midrst win", int'(win), 0);
    check("midrst credits", int'(credits), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    toggle_sclk(3);
    check("postrst busy", int'(busy), 0);
    check("postrst reel1", int'(reel1), 0);
    check("postrst credits", int'(credits), 0);
    check("postrst done", int'(done), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
